decode_stage: RTL and testbench
===============================

# decode_stage

Registered RISC-V instruction decode stage with a valid/ready handshake on both sides, sitting between instruction fetch and register read/execute. It extracts opcode, funct3, funct7, rs1, rs2, rd and the sign-extended immediate, and classifies each instruction into a one-hot format. It flags illegal encodings and supports pipeline flush. It is parametrised in immediate/PC width (RV32/RV64) and in buffering mode: a two-entry skid buffer or a single register.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets the widths of imm and pc.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  pc of the decoded instruction
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]; 0 for U/J formats
- funct7  out  7  instr[31:25] for R/I formats, else 0
- rs1  out  5  instr[19:15]; 0 for U/J formats
- rs2  out  5  instr[24:20] for R/S/B formats, else 0
- rd  out  5  instr[11:7]; 0 for S/B formats
- imm  out  XLEN  sign-extended immediate
- fmt  out  6  one-hot {J,U,B,S,I,R}
- illegal  out  1  unrecognised encoding

## Operation
- Opcode classes:
  - R: 0110011.
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}); sign taken from bit 31 when XLEN=64.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- illegal = 1 when instr[1:0] ≠ 11 or the opcode is in no class.
  - Illegal instructions still propagate with fmt = 0, imm = 0 and funct3/funct7/rs1/rs2/rd = 0.
  - opcode, out_pc and illegal = 1 remain visible on an illegal beat.
- A transfer occurs on a cycle with valid & ready. Decoding is done on the input side, and the registered result is presented the next cycle.
- SKID=1 state machine (main register M, skid register K):
  - EMPTY: input accepted → ONE.
  - ONE: input accepted with no output transfer → TWO (new beat into K). Input with output transfer → ONE (M reloaded). Output transfer only → EMPTY.
  - TWO: in_ready = 0. On output transfer, K moves to M → ONE.
  - out_valid = (state ≠ EMPTY). in_ready = (state ≠ TWO). Both are driven from registers.
- SKID=0: single register. in_ready = !out_valid | out_ready.
- Ordering is strict FIFO; no loss, duplication or reordering.
- flush has priority over everything:
  - The next state is EMPTY.
  - Any beat accepted in the flush cycle is discarded.
  - A downstream transfer in the flush cycle still counts as consumed.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high, in both modes.
- Reset (asynchronous):
  - out_valid = 0, in_ready = 0 while rst is high.
  - All data outputs = 0 and state = EMPTY.
  - in_ready = 1 in the first cycle after rst deasserts.
- Reset mid-stream drops all held instructions.
- A flush in cycle n gives out_valid = 0 and in_ready = 1 in cycle n+1.
- Data outputs are stable while out_valid & !out_ready. They are don't-care while out_valid = 0.

## Structure
- Package decode_pkg holds:
  - opcode localparams;
  - the fmt bit indices/enum;
  - the skid state enum {EMPTY, ONE, TWO};
  - a packed struct decoded_t (opcode, funct3, funct7, rs1, rs2, rd, imm, fmt, illegal, pc).
- Sub-module decode_fields (combinational, XLEN-parametrised) maps instruction + pc to decoded_t.
- decode_stage instantiates decode_fields once and contains the buffer FSM.

## Test plan
- XLEN=32: 0xFFF10093 (addi x1,x2,-1) → fmt = I, rd = 1, rs1 = 2, rs2 = 0, funct7 = 0x7F, imm = 0xFFFFFFFF, out_valid exactly one cycle after accept.
- 0xFE000EE3 (beq x0,x0,-4) → fmt = B, rd = 0, imm = 0xFFFFFFFC. XLEN=64, 0x800002B7 (lui x5) → imm = 0xFFFFFFFF80000000, rd = 5.
- 0x00000000 and 0x0000007F → illegal = 1, fmt = 0, imm = 0.
- SKID=1, stream A,B,C at 1/cycle with out_ready low for 3 cycles:
  - in_ready drops after B is captured and C is held upstream.
  - After release, out delivers A,B,C on consecutive cycles.
- Flush in state TWO with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the flushed beat never appears.
- rst asserted asynchronously mid-stream → outputs zero immediately. Both SKID modes sustain 1/cycle for 16 back-to-back instructions.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, format indices, skid states and the decoded beat record
package decode_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_idx_t;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

   // imm and pc are held at the widest XLEN; narrower stages use the low bits
   typedef struct packed {
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN_MAX-1:0] imm;
      logic [5:0]          fmt;
      logic                illegal;
      logic [XLEN_MAX-1:0] pc;
   } decoded_t;
endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational field extraction, format classification and immediate build
module decode_fields
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   output decoded_t        d
);
   logic [6:0] op;
   logic r, i, s, b, u, j;
   assign op = instr[6:0];
   assign r = op == OP_R;
   assign i = op inside {OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM};
   assign s = op == OP_STORE;
   assign b = op == OP_BRANCH;
   assign u = op inside {OP_LUI, OP_AUIPC};
   assign j = op == OP_JAL;
   // fields are gated by format, so an unclassified opcode leaves them all zero
   always_comb begin
      d         = '0;
      d.opcode  = op;
      d.funct3  = (r | i | s | b) ? instr[14:12] : '0;
      d.funct7  = (r | i) ? instr[31:25] : '0;
      d.rs1     = (r | i | s | b) ? instr[19:15] : '0;
      d.rs2     = (r | s | b) ? instr[24:20] : '0;
      d.rd      = (r | i | u | j) ? instr[11:7] : '0;
      d.imm     = i ? {{52{instr[31]}}, instr[31:20]} :
                  s ? {{52{instr[31]}}, instr[31:25], instr[11:7]} :
                  b ? {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                  u ? {{32{instr[31]}}, instr[31:12], 12'b0} :
                  j ? {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} : '0;
      d.fmt     = {j, u, b, s, i, r};
      d.illegal = (instr[1:0] != 2'b11) | !(r | i | s | b | u | j);
      d.pc      = XLEN_MAX'(pc);
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with valid/ready handshake, skid or single-register buffering
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [5:0]      fmt,
   output logic            illegal
);
   decoded_t dec, m;
   logic in_fire, out_fire, unused_hi;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   decode_fields #(.XLEN(XLEN)) u_fields (.instr(in_instr), .pc(in_pc), .d(dec));

   generate
      if (SKID) begin : g_skid
         skid_state_t state, nxt;
         decoded_t k, m_n, k_n;
         logic rdy;
         // M always holds the head beat; K catches the beat that arrives while M is stalled
         always_comb begin
            nxt = state;
            m_n = m;
            k_n = k;
            case (state)
               EMPTY: begin
                  nxt = in_fire ? ONE : EMPTY;
                  m_n = in_fire ? dec : m;
               end
               ONE: begin
                  nxt = (in_fire & !out_fire) ? TWO : (!in_fire & out_fire) ? EMPTY : ONE;
                  m_n = (in_fire & out_fire) ? dec : m;
                  k_n = (in_fire & !out_fire) ? dec : k;
               end
               TWO: begin
                  nxt = out_fire ? ONE : TWO;
                  m_n = out_fire ? k : m;
               end
               default: nxt = EMPTY;
            endcase
            if (flush) nxt = EMPTY;
         end
         // state, buffers and a registered in_ready that stays low through reset
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= EMPTY;
               m     <= '0;
               k     <= '0;
               rdy   <= 1'b0;
            end else begin
               state <= nxt;
               m     <= m_n;
               k     <= k_n;
               rdy   <= nxt != TWO;
            end
         end
         assign out_valid = state != EMPTY;
         assign in_ready  = rdy;
      end else begin : g_reg
         logic vld, alive;
         // single output register; alive keeps in_ready low until the first clock out of reset
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld   <= 1'b0;
               m     <= '0;
               alive <= 1'b0;
            end else begin
               vld   <= !flush & (in_fire | (vld & !out_fire));
               m     <= in_fire ? dec : m;
               alive <= 1'b1;
            end
         end
         assign out_valid = vld;
         assign in_ready  = alive & (!vld | out_ready);
      end
   endgenerate

   assign out_pc    = m.pc[XLEN-1:0];
   assign opcode    = m.opcode;
   assign funct3    = m.funct3;
   assign funct7    = m.funct7;
   assign rs1       = m.rs1;
   assign rs2       = m.rs2;
   assign rd        = m.rd;
   assign imm       = m.imm[XLEN-1:0];
   assign fmt       = m.fmt;
   assign illegal   = m.illegal;
   assign unused_hi = ^{m.imm, m.pc};
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard-checked bench for an RV32 skid stage and an RV64 single-register stage
module tb_decode_stage;
   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic [5:0]  fmt;
      logic        illegal;
      logic [63:0] pc;
   } beat_t;

   logic clk = 0, rst = 1, rst_q = 1, flush = 0, out_ready = 1, a_valid = 0, b_valid = 0;
   logic [31:0] instr = 0;
   logic [63:0] pc = 0;
   int checks = 0, errors = 0, a_outs = 0, b_outs = 0;
   beat_t qa[$], qb[$];
   logic [31:0] prog [8] = '{32'h002081B3, 32'hFFF10093, 32'h0011A223, 32'hFE000EE3,
                             32'h800002B7, 32'h00001517, 32'h008000EF, 32'h0000007F};

   logic a_in_ready, a_out_valid, a_illegal, b_in_ready, b_out_valid, b_illegal;
   logic [31:0] a_out_pc, a_imm;
   logic [63:0] b_out_pc, b_imm;
   logic [6:0] a_opcode, a_funct7, b_opcode, b_funct7;
   logic [2:0] a_funct3, b_funct3;
   logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
   logic [5:0] a_fmt, b_fmt;

   decode_stage #(.XLEN(32), .SKID(1'b1)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(a_valid), .in_ready(a_in_ready),
      .in_instr(instr), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_out_pc), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7), .rs1(a_rs1),
      .rs2(a_rs2), .rd(a_rd), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal));

   decode_stage #(.XLEN(64), .SKID(1'b0)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(b_valid), .in_ready(b_in_ready),
      .in_instr(instr), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7), .rs1(b_rs1),
      .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal));

   always #5 clk = ~clk;
   always @(posedge clk) rst_q <= rst;

   // reference decode straight from the format table and immediate rules
   function automatic beat_t model(input logic [31:0] w, input logic [63:0] p);
      beat_t e;
      byte c;
      string order = "RISBUJ";
      longint sgn, v;
      e = '0;
      e.opcode = w[6:0];
      e.pc = p;
      case (w[6:0])
         7'b0110011: c = "R";
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: c = "I";
         7'b0100011: c = "S";
         7'b1100011: c = "B";
         7'b0110111, 7'b0010111: c = "U";
         7'b1101111: c = "J";
         default: c = "X";
      endcase
      if (w[1:0] != 2'b11) c = "X";
      if (c == "X") begin
         e.illegal = 1'b1;
         return e;
      end
      for (int n = 0; n < 6; n++) if (order[n] == c) e.fmt[n] = 1'b1;
      if (c != "U" && c != "J") begin
         e.funct3 = w[14:12];
         e.rs1 = w[19:15];
      end
      if (c == "R" || c == "I") e.funct7 = w[31:25];
      if (c == "R" || c == "S" || c == "B") e.rs2 = w[24:20];
      if (c != "S" && c != "B") e.rd = w[11:7];
      sgn = w[31] ? -1 : 0;
      v = 0;
      case (c)
         "I": v = (sgn << 12) | w[31:20];
         "S": v = (sgn << 12) | {w[31:25], w[11:7]};
         "B": v = (sgn << 13) | {w[31], w[7], w[30:25], w[11:8], 1'b0};
         "U": v = (sgn << 32) | {w[31:12], 12'b0};
         "J": v = (sgn << 21) | {w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: v = 0;
      endcase
      e.imm = v;
      return e;
   endfunction

   task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // every-cycle scoreboard for both stages: occupancy, handshake and head-beat contents
   always @(negedge clk) begin
      beat_t ga, gb, ea, eb;
      ga = {a_opcode, a_funct3, a_funct7, a_rs1, a_rs2, a_rd, 32'b0, a_imm, a_fmt, a_illegal, 32'b0, a_out_pc};
      gb = {b_opcode, b_funct3, b_funct7, b_rs1, b_rs2, b_rd, b_imm, b_fmt, b_illegal, b_out_pc};
      if (rst || rst_q) begin
         qa.delete();
         qb.delete();
      end else begin
         chk("a_out_valid", a_out_valid, qa.size() != 0);
         chk("a_in_ready", a_in_ready, qa.size() < 2);
         if (a_out_valid && qa.size() != 0) begin
            ea = qa[0];
            ea.imm[63:32] = '0;
            ea.pc[63:32] = '0;
            chk("a_beat", ga, ea);
         end
         if (a_out_valid && out_ready) begin
            if (qa.size() != 0) void'(qa.pop_front());
            a_outs++;
         end
         if (flush) qa.delete();
         else if (a_valid && a_in_ready) qa.push_back(model(instr, pc));
         chk("b_out_valid", b_out_valid, qb.size() != 0);
         chk("b_in_ready", b_in_ready, qb.size() == 0 || out_ready);
         if (b_out_valid && qb.size() != 0) begin
            eb = qb[0];
            chk("b_beat", gb, eb);
         end
         if (b_out_valid && out_ready) begin
            if (qb.size() != 0) void'(qb.pop_front());
            b_outs++;
         end
         if (flush) qb.delete();
         else if (b_valid && b_in_ready) qb.push_back(model(instr, pc));
      end
   end

   task automatic issue(input bit sel, input logic [31:0] w, input logic [63:0] p);
      instr = w;
      pc = p;
      if (sel) b_valid = 1; else a_valid = 1;
      chk("lat_before", sel ? b_out_valid : a_out_valid, 0);
      tick;
      a_valid = 0;
      b_valid = 0;
      chk("lat_after", sel ? b_out_valid : a_out_valid, 1);
   endtask

   task automatic burst(input bit sel);
      int n0;
      out_ready = 1;
      n0 = sel ? b_outs : a_outs;
      for (int n = 0; n < 16; n++) begin
         instr = prog[n % 8];
         pc = 64'h1000 + 64'(4 * n);
         if (sel) b_valid = 1; else a_valid = 1;
         chk("thru_ready", sel ? b_in_ready : a_in_ready, 1);
         tick;
      end
      a_valid = 0;
      b_valid = 0;
      tick;
      chk("thru_count", (sel ? b_outs : a_outs) - n0, 16);
   endtask

   initial begin
      bit ok;
      repeat (2) tick;
      chk("rst_a_ready", a_in_ready, 0);
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_b_ready", b_in_ready, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_a_imm", a_imm, 0);
      rst = 0;
      tick;
      chk("a_ready_after_rst", a_in_ready, 1);
      chk("b_ready_after_rst", b_in_ready, 1);

      issue(0, 32'hFFF10093, 64'h100);
      chk("addi_fmt", a_fmt, 6'b000010);
      chk("addi_rd", a_rd, 1);
      chk("addi_rs1", a_rs1, 2);
      chk("addi_rs2", a_rs2, 0);
      chk("addi_funct7", a_funct7, 7'h7F);
      chk("addi_imm", a_imm, 32'hFFFFFFFF);
      chk("addi_pc", a_out_pc, 32'h100);
      tick;
      issue(0, 32'hFE000EE3, 64'h104);
      chk("beq_fmt", a_fmt, 6'b001000);
      chk("beq_rd", a_rd, 0);
      chk("beq_imm", a_imm, 32'hFFFFFFFC);
      tick;
      issue(0, 32'h00000000, 64'h108);
      chk("zero_illegal", a_illegal, 1);
      chk("zero_fmt", a_fmt, 0);
      chk("zero_imm", a_imm, 0);
      chk("zero_pc", a_out_pc, 32'h108);
      tick;
      issue(0, 32'h0000007F, 64'h10C);
      chk("op7f_illegal", a_illegal, 1);
      chk("op7f_fmt", a_fmt, 0);
      chk("op7f_opcode", a_opcode, 7'h7F);
      chk("op7f_imm", a_imm, 0);
      tick;
      issue(1, 32'h800002B7, 64'h1_0000_0010);
      chk("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
      chk("lui64_rd", b_rd, 5);
      chk("lui64_fmt", b_fmt, 6'b010000);
      chk("lui64_pc", b_out_pc, 64'h1_0000_0010);
      tick;

      // skid: A, B captured while stalled, C held upstream until the drain frees a slot
      out_ready = 0;
      a_valid = 1;
      instr = prog[0];
      pc = 64'h200;
      tick;
      instr = prog[2];
      pc = 64'h204;
      tick;
      instr = prog[6];
      pc = 64'h208;
      chk("skid_full_ready", a_in_ready, 0);
      chk("skid_head_pc", a_out_pc, 32'h200);
      tick;
      tick;
      chk("skid_still_full", a_in_ready, 0);
      out_ready = 1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("skid_drain_valid", a_out_valid, 1);
         chk("skid_drain_pc", a_out_pc, 32'h200 + 32'(4 * n));
         ok = a_in_ready;
         @(posedge clk);
         #1;
         if (ok) a_valid = 0;
      end
      tick;

      // flush while full with a beat waiting upstream
      out_ready = 0;
      a_valid = 1;
      instr = prog[1];
      pc = 64'h300;
      tick;
      pc = 64'h304;
      tick;
      pc = 64'h308;
      chk("flush_pre_ready", a_in_ready, 0);
      flush = 1;
      tick;
      flush = 0;
      a_valid = 0;
      chk("flush_valid", a_out_valid, 0);
      chk("flush_ready", a_in_ready, 1);
      out_ready = 1;
      repeat (3) tick;

      // flush on the same cycle a beat is accepted, on both stages
      out_ready = 0;
      a_valid = 1;
      b_valid = 1;
      instr = prog[3];
      pc = 64'h400;
      tick;
      b_valid = 0;
      pc = 64'h404;
      flush = 1;
      tick;
      flush = 0;
      a_valid = 0;
      chk("flush_one_a_valid", a_out_valid, 0);
      chk("flush_one_b_valid", b_out_valid, 0);
      out_ready = 1;
      repeat (2) tick;

      burst(0);
      burst(1);

      // asynchronous reset while both stages hold a beat
      out_ready = 0;
      a_valid = 1;
      b_valid = 1;
      instr = prog[5];
      pc = 64'h500;
      tick;
      a_valid = 0;
      b_valid = 0;
      #2 rst = 1;
      #1;
      chk("arst_a_valid", a_out_valid, 0);
      chk("arst_a_ready", a_in_ready, 0);
      chk("arst_a_pc", a_out_pc, 0);
      chk("arst_a_opcode", a_opcode, 0);
      chk("arst_a_imm", a_imm, 0);
      chk("arst_b_valid", b_out_valid, 0);
      chk("arst_b_ready", b_in_ready, 0);
      chk("arst_b_imm", b_imm, 0);
      tick;
      rst = 0;
      tick;
      chk("arst_a_ready_after", a_in_ready, 1);
      chk("arst_a_valid_after", a_out_valid, 0);
      chk("arst_b_valid_after", b_out_valid, 0);
      out_ready = 1;
      repeat (2) tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
